// File: rtl/wb_trace_fifo.sv
// Buffers retiring register-file writes from the core's debug write-back trace and
// drains them over a valid/ready port. Define TRACE_BYTE_MASK_EN to zero disabled bytes.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                debug_wb_pc,
    input  logic [3:0]                 debug_wb_rf_wen,
    input  logic [4:0]                 debug_wb_rf_wnum,
    input  logic [31:0]                debug_wb_rf_wdata,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [31:0]                trace_pc,
    output logic [3:0]                 trace_wen,
    output logic [4:0]                 trace_wnum,
    output logic [31:0]                trace_wdata,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic                       trace_overflow,
    output logic [CNT_W-1:0]           trace_drop_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int ENTRY_W = 32 + 4 + 5 + 32;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               full, empty;
    logic               push_req, push, pop, drop;
    logic [31:0]        wdata_store;
    logic [ENTRY_W-1:0] head;

    function automatic logic [31:0] mask_bytes(input logic [3:0] wen, input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = wen[b] ? d[b*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

`ifdef TRACE_BYTE_MASK_EN
    assign wdata_store = mask_bytes(debug_wb_rf_wen, debug_wb_rf_wdata);
`else
    assign wdata_store = debug_wb_rf_wdata;
`endif

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_req = (|debug_wb_rf_wen) && (debug_wb_rf_wnum != 5'd0);
    assign pop      = !empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Control state: pointers and drop tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_overflow <= 1'b0;
            trace_drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (drop) begin
                trace_overflow <= 1'b1;
                trace_drop_cnt <= sat_inc(trace_drop_cnt);
            end
        end
    end

    // Storage: data only, no reset
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, wdata_store};
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign trace_valid = !empty;
    assign trace_pc    = head[72:41];
    assign trace_wen   = head[40:37];
    assign trace_wnum  = head[36:32];
    assign trace_wdata = head[31:0];
    assign trace_count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo (DEPTH=16, CNT_W=16).
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic [4:0]  trace_count;
    logic        trace_overflow;
    logic [15:0] trace_drop_cnt;

    int vectors = 0;
    int fails   = 0;

    wb_trace_fifo #(.DEPTH(16), .CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_wen         (trace_wen),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .trace_count       (trace_count),
        .trace_overflow    (trace_overflow),
        .trace_drop_cnt    (trace_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wdata);
        debug_wb_pc       = pc;
        debug_wb_rf_wen   = wen;
        debug_wb_rf_wnum  = wnum;
        debug_wb_rf_wdata = wdata;
    endtask

    task automatic idle();
        set_wb(32'h0, 4'h0, 5'd0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input int cnt,
                             input logic ov, input int drops);
        chk({tag, ".valid"}, 32'(trace_valid), 32'(v));
        chk({tag, ".count"}, 32'(trace_count), 32'(cnt));
        chk({tag, ".overflow"}, 32'(trace_overflow), 32'(ov));
        chk({tag, ".drop_cnt"}, 32'(trace_drop_cnt), 32'(drops));
    endtask

    logic [31:0] exp_mask;

    initial begin
        reset       = 1'b1;
        trace_ready = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;
        chk_state("reset", 1'b0, 0, 1'b0, 0);

        // 1: single capture, visible next cycle, popped the cycle after
        trace_ready = 1'b1;
        set_wb(32'hBFC00000, 4'hF, 5'd3, 32'h12345678);
        step();
        idle();
        chk("t1.valid", 32'(trace_valid), 32'd1);
        chk("t1.pc",    trace_pc, 32'hBFC00000);
        chk("t1.wen",   32'(trace_wen), 32'hF);
        chk("t1.wnum",  32'(trace_wnum), 32'd3);
        chk("t1.wdata", trace_wdata, 32'h12345678);
        chk("t1.count", 32'(trace_count), 32'd1);
        step();
        chk_state("t1.after", 1'b0, 0, 1'b0, 0);

        // 2: filtered writes ($0 and wen=0)
        set_wb(32'h100, 4'hF, 5'd0, 32'hDEAD);
        step();
        chk_state("t2.r0", 1'b0, 0, 1'b0, 0);
        set_wb(32'h104, 4'h0, 5'd5, 32'hBEEF);
        step();
        idle();
        chk_state("t2.wen0", 1'b0, 0, 1'b0, 0);

        // 3: fill past full, then drain in order
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_wb(32'h1000 + 32'(i * 4), 4'hF, 5'((i % 31) + 1), 32'(i));
            step();
        end
        idle();
        chk_state("t3.full", 1'b1, 16, 1'b1, 4);
        step();
        chk("t3.hold.wdata", trace_wdata, 32'd0);
        chk("t3.hold.pc", trace_pc, 32'h1000);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3.drain%0d", i), trace_wdata, 32'(i));
            step();
        end
        chk_state("t3.empty", 1'b0, 0, 1'b1, 4);
        step();
        chk("t3.empty_ready.count", 32'(trace_count), 32'd0);

        // 4: push and pop together while full
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_wb(32'h2000, 4'hF, 5'd7, 32'(100 + i));
            step();
        end
        idle();
        chk_state("t4.full", 1'b1, 16, 1'b1, 4);
        trace_ready = 1'b1;
        set_wb(32'h2040, 4'hF, 5'd8, 32'hAA);
        step();
        idle();
        trace_ready = 1'b0;
        chk_state("t4.pushpop", 1'b1, 16, 1'b1, 4);
        trace_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t4.drain%0d", i), trace_wdata, 32'(100 + i));
            step();
        end
        chk("t4.last", trace_wdata, 32'hAA);
        chk("t4.last.wnum", 32'(trace_wnum), 32'd8);
        step();
        chk_state("t4.empty", 1'b0, 0, 1'b1, 4);

        // 5: reset mid-stream, with a push presented during reset
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_wb(32'h3000, 4'hF, 5'd9, 32'(i));
            step();
        end
        chk_state("t5.pre", 1'b1, 5, 1'b1, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        chk_state("t5.post", 1'b0, 0, 1'b0, 0);
        step();
        chk_state("t5.settle", 1'b0, 0, 1'b0, 0);

        // 6: partial byte enables
`ifdef TRACE_BYTE_MASK_EN
        exp_mask = 32'h0000CCDD;
`else
        exp_mask = 32'hAABBCCDD;
`endif
        set_wb(32'h4000, 4'b0011, 5'd12, 32'hAABBCCDD);
        step();
        idle();
        chk("t6.valid", 32'(trace_valid), 32'd1);
        chk("t6.wen", 32'(trace_wen), 32'h3);
        chk("t6.wdata", trace_wdata, exp_mask);
        trace_ready = 1'b1;
        step();
        chk_state("t6.empty", 1'b0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
